// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle between the read-side drain stage, the async FIFO read port and the downstream stream.
// slave is the adapter's view; master is the surrounding logic (FIFO + stream sink).
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4
);
    localparam int LW = $clog2(BUF_DEPTH + 1);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rd_error;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [LW-1:0]    level;
    logic [7:0]       err_cnt;

    modport slave (
        input  fifo_empty, fifo_rdata, fifo_rd_error, m_ready,
        output fifo_rd_en, m_valid, m_data, level, err_cnt
    );

    modport master (
        output fifo_empty, fifo_rdata, fifo_rd_error, m_ready,
        input  fifo_rd_en, m_valid, m_data, level, err_cnt
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain stage: issues FIFO reads only when buffer space is guaranteed, absorbs the
// one-cycle read latency in a small circular buffer and presents a valid/ready stream.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic                    rd_clk_i,
    input  logic                    rst_i,
    fifo_rd_stream_adapter_if.slave bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam logic [LW:0] DEPTH_CMP = (LW + 1)'(BUF_DEPTH);

    if (BUF_DEPTH < 3 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BUF_DEPTH must be a power of two and at least 3");
    end

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    occ;
    logic             inflight;
    logic [7:0]       err_cnt;

    logic             issue;
    logic             push;
    logic             pop;
    logic [LW:0]      committed;

    // Space check counts the word already in flight so a return can never overflow the buffer.
    always_comb begin
        committed = {1'b0, occ} + {{LW{1'b0}}, inflight};
        issue     = !rst_i && !bus.fifo_empty && (committed < DEPTH_CMP);
        push      = inflight && !bus.fifo_rd_error;
        pop       = (occ != '0) && bus.m_ready;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            err_cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= issue;

            if (push) begin
                mem[wr_ptr] <= bus.fifo_rdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + LW'(1);
                2'b01:   occ <= occ - LW'(1);
                default: occ <= occ;
            endcase

            // Errors are counted even with no read outstanding; saturate so the debug count never wraps.
            if (bus.fifo_rd_error && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign bus.fifo_rd_en = issue;
    assign bus.m_valid    = (occ != '0);
    assign bus.m_data     = mem[rd_ptr];
    assign bus.level      = occ;
    assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: FIFO model + driver issue expected words, a monitor pops and compares.
module tb_fifo_rd_stream_adapter;
    logic clk;
    logic rst;

    fifo_rd_stream_adapter_if #(.WIDTH(8), .BUF_DEPTH(4)) bus();

    fifo_rd_stream_adapter #(.WIDTH(8), .BUF_DEPTH(4)) dut (
        .rd_clk_i (clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    int cyc      = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] sb[$];

    logic       rst_drv     = 1'b1;
    logic       ready_drv   = 1'b0;
    logic       gate_toggle = 1'b0;
    logic       err_force   = 1'b0;
    logic       err_tgt_en  = 1'b0;
    logic [7:0] err_tgt     = 8'h00;
    logic       pend        = 1'b0;
    logic [7:0] pend_word   = 8'h00;
    logic       last_rd     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One read-domain cycle: drive at the falling edge, sample rd_en, model the FIFO's read latency.
    task automatic step();
        logic err;
        @(negedge clk);
        rst = rst_drv;
        if (pend) begin
            err = err_force || (err_tgt_en && pend_word == err_tgt);
            bus.fifo_rdata    = pend_word;
            bus.fifo_rd_error = err;
            if (!rst_drv && !err) sb.push_back(pend_word);
        end else begin
            bus.fifo_rdata    = 8'hEE;
            bus.fifo_rd_error = err_force;
        end
        if (rst_drv) sb.delete();
        bus.fifo_empty = (fifo_q.size() == 0) || (gate_toggle && cyc[0]);
        bus.m_ready    = ready_drv;
        #1;
        last_rd = bus.fifo_rd_en;
        if (bus.fifo_empty) chk("rd_en_while_empty", {31'd0, last_rd}, 32'd0);
        if (last_rd && fifo_q.size() != 0) begin
            pend_word = fifo_q.pop_front();
            pend      = 1'b1;
        end else begin
            pend = 1'b0;
        end
        cyc++;
        #2;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        if (pops < target) chk({name, "_timeout"}, pops, target);
    endtask

    // Monitor: compares every accepted word against the scoreboard and checks stall stability.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (prev_stall) begin
                    chk("stall_valid_hold", {31'd0, bus.m_valid}, 32'd1);
                    chk("stall_data_hold", {24'd0, bus.m_data}, {24'd0, prev_data});
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("stream_data", {24'd0, bus.m_data}, {24'd0, sb.pop_front()});
                    end
                    pops++;
                end
            end
            prev_stall = !rst && bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_count;
        int n;
        int p0;
        rst = 1'b1;
        bus.fifo_empty    = 1'b1;
        bus.fifo_rdata    = 8'h00;
        bus.fifo_rd_error = 1'b0;
        bus.m_ready       = 1'b0;

        // Reset held three cycles with a non-empty FIFO
        fifo_q = '{8'h11};
        rst_drv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_rd_en", {31'd0, last_rd}, 32'd0);
            chk("reset_valid", {31'd0, bus.m_valid}, 32'd0);
            chk("reset_level", {29'd0, bus.level}, 32'd0);
            chk("reset_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        end
        fifo_q.delete();
        rst_drv = 1'b0;
        step();
        chk("post_reset_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("post_reset_data", {24'd0, bus.m_data}, 32'd0);
        chk("post_reset_level", {29'd0, bus.level}, 32'd0);

        // Single word latency
        ready_drv = 1'b1;
        fifo_q = '{8'hA5};
        step();
        chk("single_rd_n", {31'd0, last_rd}, 32'd1);
        step();
        chk("single_rd_n1", {31'd0, last_rd}, 32'd0);
        chk("single_valid_n1", {31'd0, bus.m_valid}, 32'd0);
        step();
        chk("single_valid_n2", {31'd0, bus.m_valid}, 32'd1);
        chk("single_data_n2", {24'd0, bus.m_data}, 32'hA5);
        step();
        chk("single_valid_n3", {31'd0, bus.m_valid}, 32'd0);
        chk("single_level_n3", {29'd0, bus.level}, 32'd0);

        // Streaming 16 words at full rate
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("stream_rd_en", {31'd0, last_rd}, 32'd1);
            chk("stream_valid", {31'd0, bus.m_valid}, (i >= 2) ? 32'd1 : 32'd0);
        end
        wait_pops(p0 + 16, 10, "stream_drain");
        step();
        chk("stream_idle_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Backpressure: exactly BUF_DEPTH reads then hold
        ready_drv = 1'b0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h20 + 8'(i));
        rd_count = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_rd) rd_count++;
        end
        chk("bp_read_count", rd_count, 32'd4);
        chk("bp_level", {29'd0, bus.level}, 32'd4);
        chk("bp_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("bp_head_data", {24'd0, bus.m_data}, 32'h20);
        p0 = pops;
        ready_drv = 1'b1;
        step();
        chk("bp_first_pop_no_rd", {31'd0, last_rd}, 32'd0);
        step();
        chk("bp_resume_rd", {31'd0, last_rd}, 32'd1);
        n = 2;
        while (pops < p0 + 10 && n < 40) begin
            step();
            n++;
        end
        chk("bp_drain_cycles", n, 32'd10);
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Empty flag toggling every cycle
        gate_toggle = 1'b1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
        wait_pops(pops + 8, 60, "gate_drain");
        gate_toggle = 1'b0;
        step();
        step();
        chk("gate_sb_empty", sb.size(), 32'd0);

        // Read error on the return of word 3 discards it
        err_tgt    = 8'h43;
        err_tgt_en = 1'b1;
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'h40 + 8'(i));
        wait_pops(pops + 5, 40, "err_drain");
        step();
        step();
        err_tgt_en = 1'b0;
        chk("err_cnt_one", {24'd0, bus.err_cnt}, 32'd1);
        chk("err_sb_empty", sb.size(), 32'd0);

        // Saturation of the error counter
        err_force = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 10)  chk("err_cnt_11", {24'd0, bus.err_cnt}, 32'd11);
            if (i == 254) chk("err_cnt_255", {24'd0, bus.err_cnt}, 32'd255);
        end
        err_force = 1'b0;
        step();
        chk("err_cnt_sat", {24'd0, bus.err_cnt}, 32'd255);

        // Reset with two words buffered and one in flight
        ready_drv = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h50 + 8'(i));
        step();
        chk("mid_rd_c0", {31'd0, last_rd}, 32'd1);
        step();
        step();
        chk("mid_rd_c2", {31'd0, last_rd}, 32'd1);
        rst_drv = 1'b1;
        step();
        chk("mid_level_pre", {29'd0, bus.level}, 32'd2);
        chk("mid_rd_gated", {31'd0, last_rd}, 32'd0);
        rst_drv = 1'b0;
        step();
        chk("mid_level_post", {29'd0, bus.level}, 32'd0);
        chk("mid_valid_post", {31'd0, bus.m_valid}, 32'd0);
        chk("mid_err_cnt_post", {24'd0, bus.err_cnt}, 32'd0);
        ready_drv = 1'b1;
        wait_pops(pops + 5, 40, "mid_drain");
        for (int i = 0; i < 4; i++) step();
        chk("mid_sb_empty", sb.size(), 32'd0);
        chk("final_valid", {31'd0, bus.m_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
